axis_bram_reader: RTL and testbench

Streams the contents of a BRAM region out on an AXI4-Stream master. It is the read-side counterpart of `axis_bram_writer`: it drives BRAM port A address and enable, and captures read data. It then delivers words in address order on `m_axis` with full tready backpressure, wrapping continuously over a configurable address range. It sits between a BRAM filled by the PS (or by a writer) and downstream stream consumers such as DAC or width-converter chains.

---
 rtl/axis_bram_pkg.sv | 35 +++
 rtl/axis_bram_reader_fifo.sv | 72 +++++++
 rtl/axis_bram_reader.sv | 197 +++++++++++++++++++
 tb/tb_axis_bram_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/axis_bram_pkg.sv
// Shared definitions for the AXI4-Stream BRAM reader.
//
// Contents:
//   FIFO_DEPTH      - number of entries in the output FIFO
//   CREDIT_WIDTH    - width of occupancy / credit counters (holds 0..FIFO_DEPTH)
//   FIFO_DATA_WIDTH - width of the data word carried through the FIFO
//   fifo_entry_t    - FIFO entry: data, plus the end-of-pass flag when
//                     AXIS_BRAM_READER_TLAST_EN is defined
//   credits()       - free FIFO slots not yet claimed by reads in flight
package axis_bram_pkg;

    localparam int FIFO_DEPTH      = 4;
    localparam int CREDIT_WIDTH    = 3;
    localparam int FIFO_DATA_WIDTH = 64;

    typedef struct packed {
        logic [FIFO_DATA_WIDTH-1:0] data;
`ifdef AXIS_BRAM_READER_TLAST_EN
        logic                       last;
`endif
    } fifo_entry_t;

    // Slots that a new read may still claim: every read issued to the BRAM
    // or returning from it already owns a slot even though it is not yet
    // in the FIFO.
    function automatic logic [CREDIT_WIDTH-1:0] credits(
        input logic [CREDIT_WIDTH-1:0] occupancy,
        input logic                    rd_issued,
        input logic                    rd_returning
    );
        return CREDIT_WIDTH'(FIFO_DEPTH) - occupancy
               - {2'b00, rd_issued} - {2'b00, rd_returning};
    endfunction

endpackage

// File: rtl/axis_bram_reader_fifo.sv
// Output FIFO of the BRAM reader: four entries, organised as a shift register
// so the head entry (and therefore the stream outputs) comes straight from a
// flop.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_entry this edge (never asserted when full)
//   push_entry  - entry to store
//   pop         - drop the head entry this edge (never asserted when empty)
//   head        - oldest entry
//   valid       - FIFO not empty (registered)
//   count       - occupancy 0..FIFO_DEPTH
module axis_bram_reader_fifo
    import axis_bram_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  fifo_entry_t             push_entry,
    input  logic                    pop,
    output fifo_entry_t             head,
    output logic                    valid,
    output logic [CREDIT_WIDTH-1:0] count
);

    fifo_entry_t [FIFO_DEPTH-1:0] mem_r;
    fifo_entry_t [FIFO_DEPTH-1:0] mem_s;
    logic [CREDIT_WIDTH-1:0]      count_r;
    logic [CREDIT_WIDTH-1:0]      count_s;
    logic                         valid_r;
    logic [1:0]                   wr_idx_s;

    // Next storage contents: shift on pop, write at the first free slot.
    always_comb begin
        mem_s    = mem_r;
        wr_idx_s = count_r[1:0];
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                mem_s[i] = mem_r[i+1];
            end
            // With count 4 the low bits are 0 and wrap to 3, the slot
            // vacated by the shift.
            wr_idx_s = count_r[1:0] - 2'd1;
        end else begin
            wr_idx_s = count_r[1:0];
        end
        if (push) begin
            mem_s[wr_idx_s] = push_entry;
        end else begin
            mem_s[wr_idx_s] = mem_s[wr_idx_s];
        end
        count_s = count_r + {2'b00, push} - {2'b00, pop};
    end

    // Storage, occupancy and registered not-empty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r   <= '0;
            count_r <= 3'd0;
            valid_r <= 1'b0;
        end else begin
            mem_r   <= mem_s;
            count_r <= count_s;
            valid_r <= (count_s != 3'd0);
        end
    end

    assign head  = mem_r[0];
    assign valid = valid_r;
    assign count = count_r;

endmodule

// File: rtl/axis_bram_reader.sv
// Streams BRAM addresses 0..N (N = cfg_data, latched per pass) continuously
// onto an AXI4-Stream master with full tready backpressure.
//
// Optional feature: define AXIS_BRAM_READER_TLAST_EN to add m_axis_tlast,
// asserted with the word read from address N of each pass.
//
// Ports:
//   aclk, aresetn      - clock, asynchronous active-low reset
//   cfg_data           - last address of the range (inclusive)
//   sts_data           - address of the next word to be transferred
//   m_axis_*           - stream master (tdata/tvalid/tready[/tlast])
//   bram_porta_*       - BRAM port A read interface, one-cycle read latency
module axis_bram_reader
    import axis_bram_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int BRAM_DATA_WIDTH  = 64,
    parameter int BRAM_ADDR_WIDTH  = 9
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
    output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
`ifdef AXIS_BRAM_READER_TLAST_EN
    output logic                        m_axis_tlast,
`endif
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic                        bram_porta_en,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata
);

    logic                       started_r;
    logic [BRAM_ADDR_WIDTH-1:0] limit_r;
    logic [BRAM_ADDR_WIDTH-1:0] issue_addr_r;
    logic [BRAM_ADDR_WIDTH-1:0] addr_r;
    logic                       en_r;
    logic                       issue_last_r;
    logic                       rd_valid_r;
    logic                       rd_last_r;
    logic [BRAM_ADDR_WIDTH-1:0] sts_r;

    logic [BRAM_ADDR_WIDTH-1:0] lim_s;
    logic                       pass_end_s;
    logic [CREDIT_WIDTH-1:0]    credit_s;
    logic [CREDIT_WIDTH-1:0]    fifo_count_s;
    logic                       issue_s;
    logic                       xfer_s;
    logic                       head_last_s;
    logic                       fifo_valid_s;
    fifo_entry_t                push_entry_s;
    fifo_entry_t                head_s;

    // Issue decision. Before the first edge the limit register is not yet
    // loaded, so the first read compares against cfg_data directly.
    always_comb begin
        if (started_r) begin
            lim_s = limit_r;
        end else begin
            lim_s = cfg_data;
        end
        pass_end_s = (issue_addr_r == lim_s);
        credit_s   = credits(fifo_count_s, en_r, rd_valid_r);
        issue_s    = (credit_s != 3'd0);
        xfer_s     = fifo_valid_s & m_axis_tready;
    end

    // Address counter, limit register and BRAM read pipeline.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            started_r    <= 1'b0;
            limit_r      <= '0;
            issue_addr_r <= '0;
            addr_r       <= '0;
            en_r         <= 1'b0;
            issue_last_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_last_r    <= 1'b0;
        end else begin
            started_r <= 1'b1;
            // A new pass takes its limit from cfg_data when the issue
            // address wraps; mid-pass changes wait for that point.
            if (!started_r || (issue_s && pass_end_s)) begin
                limit_r <= cfg_data;
            end else begin
                limit_r <= limit_r;
            end
            if (issue_s) begin
                en_r         <= 1'b1;
                addr_r       <= issue_addr_r;
                issue_last_r <= pass_end_s;
                if (pass_end_s) begin
                    issue_addr_r <= '0;
                end else begin
                    issue_addr_r <= issue_addr_r + BRAM_ADDR_WIDTH'(1'b1);
                end
            end else begin
                en_r         <= 1'b0;
                addr_r       <= addr_r;
                issue_last_r <= issue_last_r;
                issue_addr_r <= issue_addr_r;
            end
            // Read data appears on bram_porta_rddata one cycle after the
            // BRAM samples the enable; it is pushed on the following edge.
            rd_valid_r <= en_r;
            rd_last_r  <= issue_last_r;
        end
    end

    // FIFO write entry built from the returning read.
    always_comb begin
        push_entry_s      = '0;
        push_entry_s.data = bram_porta_rddata;
`ifdef AXIS_BRAM_READER_TLAST_EN
        push_entry_s.last = rd_last_r;
`endif
    end

    axis_bram_reader_fifo u_fifo (
        .clk        (aclk),
        .rst_n      (aresetn),
        .push       (rd_valid_r),
        .push_entry (push_entry_s),
        .pop        (xfer_s),
        .head       (head_s),
        .valid      (fifo_valid_s),
        .count      (fifo_count_s)
    );

`ifdef AXIS_BRAM_READER_TLAST_EN
    assign head_last_s  = head_s.last;
    assign m_axis_tlast = head_s.last;
`else
    // Without tlast in the FIFO, the end-of-pass marks that sts_data needs
    // ride in a flag shift register that moves in step with the FIFO.
    logic [FIFO_DEPTH-1:0] lastq_r;
    logic [FIFO_DEPTH-1:0] lastq_s;
    logic [1:0]            lastq_idx_s;

    // Next end-of-pass flags: same shift/write pattern as the data FIFO.
    always_comb begin
        lastq_s     = lastq_r;
        lastq_idx_s = fifo_count_s[1:0];
        if (xfer_s) begin
            lastq_s     = {1'b0, lastq_r[FIFO_DEPTH-1:1]};
            lastq_idx_s = fifo_count_s[1:0] - 2'd1;
        end else begin
            lastq_idx_s = fifo_count_s[1:0];
        end
        if (rd_valid_r) begin
            lastq_s[lastq_idx_s] = rd_last_r;
        end else begin
            lastq_s[lastq_idx_s] = lastq_s[lastq_idx_s];
        end
    end

    // End-of-pass flag storage.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lastq_r <= '0;
        end else begin
            lastq_r <= lastq_s;
        end
    end

    assign head_last_s = lastq_r[0];
`endif

    // Next-transfer address: advances per transfer and returns to 0 after
    // the word that closed its pass, so a limit change lands exactly there.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sts_r <= '0;
        end else if (xfer_s) begin
            if (head_last_s) begin
                sts_r <= '0;
            end else begin
                sts_r <= sts_r + BRAM_ADDR_WIDTH'(1'b1);
            end
        end else begin
            sts_r <= sts_r;
        end
    end

    assign sts_data        = sts_r;
    assign m_axis_tdata    = head_s.data;
    assign m_axis_tvalid   = fifo_valid_s;
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_en   = en_r;
    assign bram_porta_addr = addr_r;

endmodule

// File: tb/tb_axis_bram_reader.sv
// Self-checking bench for axis_bram_reader. A BRAM array feeds the DUT; the
// expected stream is derived from the pass rules (addresses 0..N in order,
// N re-read from cfg_data at each pass boundary).
module tb_axis_bram_reader;

    localparam int AW = 9;
    localparam int DW = 64;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [AW-1:0] cfg_data;
    logic [AW-1:0] sts_data;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
`ifdef AXIS_BRAM_READER_TLAST_EN
    logic          m_axis_tlast;
`endif
    logic          bram_porta_clk;
    logic          bram_porta_rst;
    logic          bram_porta_en;
    logic [AW-1:0] bram_porta_addr;
    logic [DW-1:0] bram_porta_rddata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int            n_assert = 0;
    int            n_fail   = 0;
    int            exp_addr;
    int            exp_lim;
    int            issues;
    int            xfers;
    bit            prev_stall;
    logic [DW-1:0] prev_data;

    axis_bram_reader dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cfg_data          (cfg_data),
        .sts_data          (sts_data),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
`ifdef AXIS_BRAM_READER_TLAST_EN
        .m_axis_tlast      (m_axis_tlast),
`endif
        .bram_porta_clk    (bram_porta_clk),
        .bram_porta_rst    (bram_porta_rst),
        .bram_porta_en     (bram_porta_en),
        .bram_porta_addr   (bram_porta_addr),
        .bram_porta_rddata (bram_porta_rddata)
    );

    always #5 aclk = ~aclk;

    // BRAM model: one-cycle read latency.
    always @(posedge bram_porta_clk) begin
        if (bram_porta_en) bram_porta_rddata <= mem[bram_porta_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_addr   = 0;
        exp_lim    = int'(cfg_data);
        issues     = 0;
        xfers      = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
        check({tag, "_tdata"}, m_axis_tdata, 64'd0);
        check({tag, "_sts"}, {55'd0, sts_data}, 64'd0);
        check({tag, "_en"}, {63'd0, bram_porta_en}, 64'd0);
        check({tag, "_addr"}, {55'd0, bram_porta_addr}, 64'd0);
        check({tag, "_bram_rst"}, {63'd0, bram_porta_rst}, 64'd1);
`ifdef AXIS_BRAM_READER_TLAST_EN
        check({tag, "_tlast"}, {63'd0, m_axis_tlast}, 64'd0);
`endif
    endtask

    // Called at a falling edge: release reset, then verify tvalid first rises
    // after the third rising edge. Ends at the falling edge after that.
    task automatic release_and_check();
        model_reset();
        aresetn = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge aclk);
            #1;
            check($sformatf("latency_edge%0d", e), {63'd0, m_axis_tvalid}, (e == 3) ? 64'd1 : 64'd0);
            if (e < 3 && bram_porta_en) issues++;
        end
        @(negedge aclk);
    endtask

    // One clock: drive tready, check what the coming rising edge transfers,
    // update the reference model, advance to the next falling edge.
    task automatic cycle(input logic rdy);
        m_axis_tready = rdy;
        if (bram_porta_en) issues++;
        check("outstanding_le4", {63'd0, (issues - xfers) <= 4}, 64'd1);
        if (prev_stall) begin
            check("stall_hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
            check("stall_hold_data", m_axis_tdata, prev_data);
        end
        if (m_axis_tvalid && rdy) begin
            check($sformatf("tdata_a%0d", exp_addr), m_axis_tdata, mem[exp_addr]);
            check("sts_data", {55'd0, sts_data}, 64'(exp_addr));
`ifdef AXIS_BRAM_READER_TLAST_EN
            check("tlast", {63'd0, m_axis_tlast}, (exp_addr == exp_lim) ? 64'd1 : 64'd0);
`endif
            xfers++;
            if (exp_addr == exp_lim) begin
                exp_addr = 0;
                exp_lim  = int'(cfg_data);
            end else begin
                exp_addr++;
            end
        end
        prev_stall = m_axis_tvalid && !rdy;
        prev_data  = m_axis_tdata;
        @(negedge aclk);
    endtask

    initial begin
        bram_porta_rddata = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 64'(i);
        aresetn       = 1'b0;
        cfg_data      = 9'd7;
        m_axis_tready = 1'b0;
        model_reset();

        // Reset state, then first-word latency.
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        release_and_check();

        // Continuous stream, tready high: one word every clock.
        for (int i = 0; i < 24; i++) begin
            check("no_bubble", {63'd0, m_axis_tvalid}, 64'd1);
            cycle(1'b1);
        end

        // tready toggling 1-0-1-0.
        for (int i = 0; i < 24; i++) cycle(i[0] ? 1'b0 : 1'b1);

        // Random backpressure, about 30% low.
        for (int i = 0; i < 80; i++) cycle(($urandom_range(99) < 30) ? 1'b0 : 1'b1);

        // Long stall: exactly four words buffered, then full rate resumes.
        for (int i = 0; i < 12; i++) cycle(1'b0);
        check("stall_buffered", 64'(issues - xfers), 64'd4);
        for (int i = 0; i < 16; i++) begin
            check("resume_no_bubble", {63'd0, m_axis_tvalid}, 64'd1);
            cycle(1'b1);
        end

        // Limit change while address 4 is being issued.
        for (int k = 0; k < 40 && !(bram_porta_en && bram_porta_addr == 9'd4); k++) cycle(1'b1);
        check("saw_issue_a4", {63'd0, bram_porta_en && bram_porta_addr == 9'd4}, 64'd1);
        cfg_data = 9'd3;
        for (int i = 0; i < 30; i++) cycle(($urandom_range(99) < 20) ? 1'b0 : 1'b1);

        // Reset pulse with tready low and FIFO full.
        for (int i = 0; i < 10; i++) cycle(1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge aclk);
        @(negedge aclk);
        release_and_check();
        for (int i = 0; i < 16; i++) cycle(1'b1);

        // N = 0: every word is word[0].
        aresetn  = 1'b0;
        cfg_data = 9'd0;
        mem[0]   = {$urandom, $urandom};
        @(negedge aclk);
        @(negedge aclk);
        release_and_check();
        for (int i = 0; i < 20; i++) cycle(($urandom_range(99) < 30) ? 1'b0 : 1'b1);
        check("n0_transfers_seen", {63'd0, xfers > 8}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
